// File: rtl/mmm_pkg.sv
// Shared constants and word arithmetic for the carry-save Montgomery datapath.
// Latency: n/a (package). Backpressure: n/a.
// Exports: DEF_K, W, CW, NW, IDXW, rw_t, word_sum_t, word_add(), nw_of().
package mmm_pkg;

  localparam int DEF_K = 1024;             // default operand size in bits
  localparam int W     = 16;               // word size in bits
  localparam int CW    = 4;                // inter-word carry width (cy <= 8)
  localparam int NW    = DEF_K / W + 1;    // words per frame, one growth word
  localparam int IDXW  = $clog2(NW);       // word index width

  // Redundant word: W bits plus two bits of carry-save growth.
  typedef logic [W+1:0] rw_t;

  // Layout matches the W+CW-bit sum vector: carry on top, word below.
  typedef struct packed {
    logic [CW-1:0] cy;
    logic [W-1:0]  word;
  } word_sum_t;

  // s + c + cy, computed W+CW bits wide.
  function automatic word_sum_t word_add(input rw_t s, input rw_t c,
                                         input logic [CW-1:0] cy);
    logic [W+CW-1:0] t;
    t = {{(CW-2){1'b0}}, s} + {{(CW-2){1'b0}}, c} + {{W{1'b0}}, cy};
    return word_sum_t'(t);
  endfunction

  // Words per frame for an operand of k bits.
  function automatic int nw_of(input int k);
    return k / W + 1;
  endfunction

endpackage

// File: rtl/csa_resolve_if.sv
// Handshake bundle between the PE chain, csa_resolve and the result sink.
// Latency: n/a (wires only). Backpressure: in_ready / out_ready.
// master = stimulus/consumer side, slave = csa_resolve. IW = word index width.
interface csa_resolve_if
  import mmm_pkg::*;
#(
  parameter int IW = IDXW
) ();

  logic          in_valid;
  logic          in_ready;
  rw_t           in_s;
  rw_t           in_c;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_word;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic [CW-1:0] out_carry;
  logic          out_ovf;
  logic          busy;

  modport master (
    output in_valid, in_s, in_c, out_ready,
    input  in_ready, out_valid, out_word, out_idx, out_last, out_carry,
           out_ovf, busy
  );

  modport slave (
    input  in_valid, in_s, in_c, out_ready,
    output in_ready, out_valid, out_word, out_idx, out_last, out_carry,
           out_ovf, busy
  );

endinterface

// File: rtl/csa_word_add.sv
// Combinational three-operand word adder: s + c + cy -> W-bit word, new carry.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: s, c (W+2 redundant), cy (CW) in; word (W), cy_next (CW) out.
module csa_word_add
  import mmm_pkg::*;
(
  input  rw_t           s,
  input  rw_t           c,
  input  logic [CW-1:0] cy,
  output logic [W-1:0]  word,
  output logic [CW-1:0] cy_next
);

  word_sum_t sum;

  always_comb begin
    sum     = word_add(s, c, cy);
    word    = sum.word;
    cy_next = sum.cy;
  end

endmodule

// File: rtl/csa_resolve.sv
// Resolves the PE chain's carry-save word stream into binary words, LSW first.
// Latency: 1 cycle from input accept to out_valid; 1 word/cycle sustained.
// Backpressure: in_ready = !out_valid || out_ready; a stall freezes word_cnt/cy.
// Ports: clk, rst (sync, active-high), bus (csa_resolve_if.slave).
module csa_resolve
  import mmm_pkg::*;
#(
  parameter int K = DEF_K
) (
  input  logic           clk,
  input  logic           rst,
  csa_resolve_if.slave   bus
);

  localparam int N_WORDS = nw_of(K);
  localparam int IDX_W   = $clog2(N_WORDS);

  logic [IDX_W-1:0] word_cnt;
  logic [CW-1:0]    cy;

  logic             out_valid_q;
  logic [W-1:0]     out_word_q;
  logic [IDX_W-1:0] out_idx_q;
  logic             out_last_q;
  logic [CW-1:0]    out_carry_q;
  logic             out_ovf_q;

  logic [W-1:0]     sum_word;
  logic [CW-1:0]    cy_next;
  logic             in_ready;
  logic             in_xfer;
  logic             last_word;

  csa_word_add u_add (
    .s       (bus.in_s),
    .c       (bus.in_c),
    .cy      (cy),
    .word    (sum_word),
    .cy_next (cy_next)
  );

  // Pass-through ready: the single output slot frees up the same cycle it drains.
  assign in_ready  = !out_valid_q || bus.out_ready;
  assign in_xfer   = bus.in_valid && in_ready;
  assign last_word = (word_cnt == IDX_W'(N_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt    <= '0;
      cy          <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_carry_q <= '0;
      out_ovf_q   <= 1'b0;
    end else if (in_xfer) begin
      // A new word overwrites the slot even if it is draining this cycle.
      out_valid_q <= 1'b1;
      out_word_q  <= sum_word;
      out_idx_q   <= word_cnt;
      out_last_q  <= last_word;
      out_carry_q <= last_word ? cy_next : '0;
      out_ovf_q   <= last_word && (|cy_next);
      if (last_word) begin
        // Wrap and clear carry together so the next frame starts on this edge.
        word_cnt <= '0;
        cy       <= '0;
      end else begin
        word_cnt <= word_cnt + IDX_W'(1);
        cy       <= cy_next;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = out_word_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_carry = out_carry_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.busy      = (word_cnt != '0) || out_valid_q;

endmodule

// File: tb/tb_csa_resolve.sv
// Bench for csa_resolve with K=64 (5 words of 16 bits per frame).
// Latency: n/a. Backpressure: out_ready driven at a selectable duty.
// Expected words come from a whole-frame integer sum, queued as words are driven.
module tb_csa_resolve;

  localparam int NWF = 5;

  typedef logic [17:0] rw_t;
  typedef struct packed {
    logic [15:0] word;
    logic [2:0]  idx;
    logic        last;
    logic [3:0]  carry;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csa_resolve_if #(.IW(3)) bus ();

  csa_resolve #(.K(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t sb[$];
  rw_t  fs[NWF];
  rw_t  fc[NWF];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ready_pct = 100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Downstream ready changes just after the rising edge so it is stable all cycle.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: sample mid-cycle; a visible valid&&ready means a transfer at the next edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        check("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_out", 32'(bus.out_idx), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("word",  32'(bus.out_word),  32'(e.word));
            check("idx",   32'(bus.out_idx),   32'(e.idx));
            check("last",  32'(bus.out_last),  32'(e.last));
            check("carry", 32'(bus.out_carry), 32'(e.carry));
            check("ovf",   32'(bus.out_ovf),   32'(e.ovf));
          end
        end
      end
    end
  end

  // Drive fs/fc as one frame (or its first n_words); expectations come from the
  // exact integer sum of (s_i + c_i) * 2^(16i), independent of per-word carries.
  task automatic send_frame(input int n_words);
    logic [95:0] total;
    exp_t        e;
    int          guard;
    total = '0;
    for (int i = 0; i < NWF; i++)
      total = total + (({78'b0, fs[i]} + {78'b0, fc[i]}) << (16 * i));
    for (int i = 0; i < n_words; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_s     = fs[i];
      bus.in_c     = fc[i];
      e.word  = total[16*i +: 16];
      e.idx   = 3'(i);
      e.last  = (i == NWF - 1);
      e.carry = e.last ? total[83:80] : 4'd0;
      e.ovf   = e.last && (total[95:80] != 16'd0);
      sb.push_back(e);
      guard = 0;
      #2;
      while (!bus.in_ready && guard < 1000) begin
        @(negedge clk);
        #2;
        guard++;
      end
      if (guard >= 1000) check("in_ready_timeout", 32'(guard), 32'd0);
    end
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_s     = rw_t'($urandom);   // garbage must be ignored
    bus.in_c     = rw_t'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    // Reset held 3 cycles with a valid input present: nothing may come out.
    bus.in_valid = 1'b1;
    bus.in_s     = 18'h3FFFF;
    bus.in_c     = 18'h3FFFF;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      #2;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_word",  32'(bus.out_word),  32'd0);
      check("rst_out_idx",   32'(bus.out_idx),   32'd0);
      check("rst_out_last",  32'(bus.out_last),  32'd0);
      check("rst_out_carry", 32'(bus.out_carry), 32'd0);
      check("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
      check("rst_busy",      32'(bus.busy),      32'd0);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    end
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;

    // Carry ripple: 0x3FFFF + 1 = 0x40000 -> word0 0x0000, carry 4 into word1.
    foreach (fs[i]) begin fs[i] = '0; fc[i] = '0; end
    fs[0] = 18'h3FFFF;
    fc[0] = 18'h00001;
    send_frame(NWF);
    idle_inputs();
    drain();

    // Max operands: word0 0x7FFFE -> 0xFFFE cy 7; word1 0x7FFFE+7 = 0x80005 ->
    // 0x0005 cy 8; words 2-4 0x80006 -> 0x0006 cy 8; final carry 8, overflow set.
    foreach (fs[i]) begin fs[i] = 18'h3FFFF; fc[i] = 18'h3FFFF; end
    send_frame(NWF);
    idle_inputs();
    drain();

    // Back-to-back: frame A leaves carry 3 out of its last word, frame B is zero.
    foreach (fs[i]) begin fs[i] = '0; fc[i] = '0; end
    fs[NWF-1] = 18'h30000;
    send_frame(NWF);
    foreach (fs[i]) begin fs[i] = '0; fc[i] = '0; end
    send_frame(NWF);
    idle_inputs();
    drain();

    // Random frames under 30% downstream ready.
    ready_pct = 30;
    for (int f = 0; f < 20; f++) begin
      foreach (fs[i]) begin fs[i] = rw_t'($urandom); fc[i] = rw_t'($urandom); end
      send_frame(NWF);
      if (f % 3 == 0) idle_inputs();
    end
    idle_inputs();
    drain();
    ready_pct = 100;
    repeat (2) @(negedge clk);

    // Reset after word 2 of a frame is accepted.
    foreach (fs[i]) begin fs[i] = rw_t'($urandom); fc[i] = rw_t'($urandom); end
    send_frame(3);
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_busy",      32'(bus.busy),      32'd0);
    sb.delete();
    rst = 1'b0;
    foreach (fs[i]) begin fs[i] = rw_t'($urandom); fc[i] = rw_t'($urandom); end
    send_frame(NWF);
    idle_inputs();
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
